// File: rtl/bitwise_logic_pipe.sv
// Bitwise logic unit with an elastic, bubble-collapsing pipeline.
// Define BITWISE_LOGIC_PIPE_STATS_EN to build the accepted-transaction counter.
module bitwise_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [15:0]      op_count
);

  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0]  res_d;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  dat_q [STAGES];

  always_comb begin
    res_d = '0;
    unique case (op)
      3'd0: res_d = a & b;
      3'd1: res_d = a | b;
      3'd2: res_d = a ^ b;
      3'd3: res_d = ~(a & b);
      3'd4: res_d = ~(a | b);
      3'd5: res_d = ~(a ^ b);
      3'd6: res_d = a & ~b;
      3'd7: res_d = ~a;
    endcase
  end

  // A stage may load if any stage at or beyond it has a hole, or the sink drains.
  always_comb begin
    load = '0;
    for (int k = 0; k < STAGES; k++) begin
      load[k] = out_ready;
      for (int j = k; j < STAGES; j++)
        if (!vld_q[j]) load[k] = 1'b1;
    end
  end

  assign in_ready  = load[0] & reset;
  assign out_valid = vld_q[LAST];
  assign y         = vld_q[LAST] ? dat_q[LAST] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++)
        dat_q[k] <= '0;
    end else begin
      if (load[0]) begin
        vld_q[0] <= in_valid;
        dat_q[0] <= res_d;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

`ifdef BITWISE_LOGIC_PIPE_STATS_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && in_ready && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe (8x2 and 1x1 builds).
// Random traffic is scored against a queue-based timing/data model.
module tb_bitwise_logic_pipe;

  localparam int ST = 2;

  logic        clock;
  logic        reset;
  logic        iv, ir, ov, ordy;
  logic [2:0]  op;
  logic [7:0]  a, b, y;
  logic [15:0] cnt;

  logic        iv1, ir1, ov1, ordy1;
  logic [2:0]  op1;
  logic [0:0]  a1, b1, y1;
  logic [15:0] cnt1;

  int total = 0;
  int bad   = 0;

`ifdef BITWISE_LOGIC_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  bitwise_logic_pipe #(.WIDTH(8), .STAGES(ST)) dut (
    .clock(clock), .reset(reset),
    .in_valid(iv), .in_ready(ir),
    .op(op), .a(a), .b(b),
    .out_valid(ov), .out_ready(ordy),
    .y(y), .op_count(cnt)
  );

  bitwise_logic_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
    .clock(clock), .reset(reset),
    .in_valid(iv1), .in_ready(ir1),
    .op(op1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(ordy1),
    .y(y1), .op_count(cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Per-op truth table indexed by {a_bit, b_bit}.
  function automatic logic [7:0] mdl(input logic [2:0] o,
                                     input logic [7:0] x,
                                     input logic [7:0] z);
    logic [3:0] tt;
    logic [7:0] r;
    case (o)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0100;
      default: tt = 4'b0011;
    endcase
    for (int i = 0; i < 8; i++)
      r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    iv = 0; ordy = 1; iv1 = 0; ordy1 = 1;
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  task automatic test_reset();
    iv = 1; ordy = 1; op = 3'd1; a = 8'h11; b = 8'h22;
    step();
    step();
    iv = 0; ordy = 0;
    @(negedge clock);
    total++;
    if (ov !== 1'b1) begin
      bad++; $display("FAIL rst_prefill ov=%b want 1", ov);
    end
    #1 reset = 0;
    #1;
    total++;
    if (ov !== 1'b0 || y !== 8'h00 || ir !== 1'b0 || cnt !== 16'h0) begin
      bad++;
      $display("FAIL rst_async ov=%b y=%h ir=%b cnt=%h want 0 00 0 0",
               ov, y, ir, cnt);
    end
    @(posedge clock);
    #1 reset = 1;
    ordy = 1;
    @(negedge clock);
    total++;
    if (ir !== 1'b1) begin
      bad++; $display("FAIL rst_ready ir=%b want 1", ir);
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (ov !== 1'b0 || y !== 8'h00) begin
        bad++; $display("FAIL rst_noemit c=%0d ov=%b y=%h want 0 00", c, ov, y);
      end
      step();
      @(negedge clock);
    end
    step();
  endtask

  task automatic test_nor();
    iv = 1; ordy = 1; op = 3'd4; a = 8'hF0; b = 8'h3C;
    @(negedge clock);
    total++;
    if (ir !== 1'b1) begin
      bad++; $display("FAIL nor_ready ir=%b want 1", ir);
    end
    step();
    iv = 0;
    @(negedge clock);
    total++;
    if (ov !== 1'b0) begin
      bad++; $display("FAIL nor_early ov=%b want 0", ov);
    end
    step();
    @(negedge clock);
    total++;
    if (ov !== 1'b1 || y !== 8'h03) begin
      bad++; $display("FAIL nor_result ov=%b y=%h want 1 03", ov, y);
    end
    step();
    @(negedge clock);
    total++;
    if (ov !== 1'b0) begin
      bad++; $display("FAIL nor_dup ov=%b want 0", ov);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA,
                            8'h50, 8'h55, 8'hA0, 8'h5A};
    ordy = 1; a = 8'hA5; b = 8'h0F;
    for (int i = 0; i < 11; i++) begin
      iv = (i < 8);
      op = 3'(i);
      @(negedge clock);
      total++;
      if (i >= 2 && i < 10) begin
        if (ov !== 1'b1 || y !== exp[i-2]) begin
          bad++;
          $display("FAIL b2b_%0d ov=%b y=%h want 1 %h", i-2, ov, y, exp[i-2]);
        end
      end else if (ov !== 1'b0) begin
        bad++; $display("FAIL b2b_idle i=%0d ov=%b want 0", i, ov);
      end
      step();
    end
    iv = 0;
  endtask

  task automatic test_stall();
    logic [7:0] q[$];
    int acc = 0;
    int drained = 0;
    ordy = 0;
    for (int c = 0; c < 6; c++) begin
      iv = 1;
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clock);
      if (ir) begin
        q.push_back(mdl(op, a, b));
        acc++;
      end
      step();
    end
    iv = 0;
    total++;
    if (acc !== ST) begin
      bad++; $display("FAIL stall_accepts got=%0d want %0d", acc, ST);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      total++;
      if (ov !== 1'b1 || q.size() == 0 || y !== q[0]) begin
        bad++; $display("FAIL stall_hold c=%0d ov=%b y=%h", c, ov, y);
      end
      step();
    end
    ordy = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (ov) begin
        total++;
        if (q.size() == 0 || y !== q[0]) begin
          bad++; $display("FAIL stall_drain n=%0d y=%h", drained, y);
        end
        if (q.size() != 0) void'(q.pop_front());
        drained++;
      end
      step();
    end
    total++;
    if (drained !== ST) begin
      bad++; $display("FAIL stall_count drained=%0d want %0d", drained, ST);
    end
  endtask

  task automatic test_width1();
    logic exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    ordy1 = 1; op1 = 3'd4;
    for (int i = 0; i < 5; i++) begin
      iv1 = (i < 4);
      a1 = 1'(i % 2);
      b1 = 1'((i / 2) % 2);
      @(negedge clock);
      total++;
      if (i >= 1) begin
        if (ov1 !== 1'b1 || y1 !== exp[i-1]) begin
          bad++;
          $display("FAIL w1_%0d ov=%b y=%b want 1 %b", i-1, ov1, y1, exp[i-1]);
        end
      end else if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
        bad++; $display("FAIL w1_start ov=%b ir=%b want 0 1", ov1, ir1);
      end
      step();
    end
    iv1 = 0;
    @(negedge clock);
    total++;
    if (ov1 !== 1'b0 || y1 !== 1'b0 || cnt1 !== (STATS ? 16'd4 : 16'd0)) begin
      bad++; $display("FAIL w1_end ov=%b y=%b cnt=%0d", ov1, y1, cnt1);
    end
    step();
  endtask

  typedef struct {
    logic [7:0] d;
    int         avail;
  } item_t;

  task automatic test_random();
    item_t q[$];
    item_t it;
    int mcnt = 0;
    logic e_ready, e_ov;
    logic [7:0] e_y;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      op   = 3'($urandom_range(0, 7));
      a    = 8'($urandom);
      b    = 8'($urandom);
      @(negedge clock);
      e_ready = (q.size() < ST) || ordy;
      e_ov    = (q.size() > 0) && (q[0].avail <= cyc);
      e_y     = e_ov ? q[0].d : 8'h00;
      total++;
      if (ir !== e_ready) begin
        bad++; $display("FAIL rnd_ready cyc=%0d ir=%b want %b", cyc, ir, e_ready);
      end
      total++;
      if (ov !== e_ov || y !== e_y) begin
        bad++;
        $display("FAIL rnd_out cyc=%0d ov=%b y=%h want %b %h",
                 cyc, ov, y, e_ov, e_y);
      end
      total++;
      if (cnt !== (STATS ? 16'(mcnt) : 16'd0)) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d cnt=%0d want %0d", cyc, cnt, mcnt);
      end
      if (e_ov && ordy) void'(q.pop_front());
      if (iv && e_ready) begin
        it.d = mdl(op, a, b);
        it.avail = cyc + ST;
        q.push_back(it);
        mcnt++;
      end
      step();
    end
    iv = 0;
  endtask

  task automatic test_count_sat();
    int want;
    do_reset();
    iv = 1; ordy = 1; op = 3'd2; a = 8'h5A; b = 8'hC3;
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (n == 1 || n == 2 || n == 65534 || n == 65535 ||
          n == 65536 || n == 70000) begin
        want = STATS ? ((n > 65535) ? 65535 : n) : 0;
        total++;
        if (cnt !== 16'(want) || ir !== 1'b1) begin
          bad++;
          $display("FAIL cnt_sat n=%0d cnt=%0d ir=%b want %0d 1", n, cnt, ir, want);
        end
      end
    end
    iv = 0;
    step();
  endtask

  initial begin
    reset = 0;
    iv = 0; ordy = 1; op = 0; a = 0; b = 0;
    iv1 = 0; ordy1 = 1; op1 = 0; a1 = 0; b1 = 0;
    #1;
    total++;
    if (ov !== 1'b0 || y !== 8'h00 || ir !== 1'b0 || cnt !== 16'h0) begin
      bad++;
      $display("FAIL por ov=%b y=%h ir=%b cnt=%h want 0 00 0 0", ov, y, ir, cnt);
    end
    do_reset();
    test_reset();
    test_nor();
    test_back_to_back();
    test_stall();
    test_width1();
    test_random();
    test_count_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
